// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch initiator with a small response FIFO.
// Issues pipelined word requests on fe_*, captures returned words with
// their PC and fault cause, and hands them to decode via valid/ready.
// Redirects flush the queue and restart fetch from a new PC.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        fe_req,
  output logic [29:0] fe_addr,
  input  logic        fe_ack,
  input  logic        fe_error,
  input  logic [31:0] fe_data,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [31:0] de_insn,
  output logic [1:0]  de_cause,
  input  logic        de_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] CAUSE_OK    = 2'b00;
  localparam logic [1:0] CAUSE_FAULT = 2'b01;
  localparam logic [1:0] CAUSE_MISAL = 2'b10;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic          inflight_err;
  logic          kill;
  logic          halt;
  logic          misal_pend;

  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_insn  [DEPTH];
  logic [1:0]  q_cause [DEPTH];

  logic        accept;
  logic        rsp_push;
  logic        push;
  logic        pop;
  logic [31:0] push_pc;
  logic [31:0] push_insn;
  logic [1:0]  push_cause;

  // Request credit: only registered state plus redirect/reset gate the request
  always_comb begin
    fe_req  = 1'b0;
    fe_addr = pc[31:2];
    if (reset_n && !halt && !redirect &&
        ((count + CW'(inflight)) < CW'(DEPTH))) begin
      fe_req = 1'b1;
    end
  end

  // Push/pop decisions and the payload of the entry being written
  always_comb begin
    accept     = fe_req & fe_ack;
    rsp_push   = inflight & ~kill & ~halt & ~redirect;
    push       = rsp_push | (misal_pend & ~redirect);
    pop        = (count != '0) & de_ready & ~redirect;
    push_pc    = inflight_pc;
    push_insn  = fe_data;
    push_cause = CAUSE_OK;
    if (misal_pend) begin
      push_pc    = pc;
      push_insn  = 32'h0;
      push_cause = CAUSE_MISAL;
    end else if (inflight_err) begin
      push_insn  = 32'h0;
      push_cause = CAUSE_FAULT;
    end
  end

  // Head of queue to decode; fields read as zero while empty
  always_comb begin
    de_valid = (count != '0);
    de_pc    = 32'h0;
    de_insn  = 32'h0;
    de_cause = CAUSE_OK;
    if (de_valid) begin
      de_pc    = q_pc[rd_ptr];
      de_insn  = q_insn[rd_ptr];
      de_cause = q_cause[rd_ptr];
    end
  end

  // Control state: PC, pointers, inflight tracking, kill and halt
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= 32'h0;
      inflight_err <= 1'b0;
      kill         <= 1'b0;
      halt         <= 1'b0;
      misal_pend   <= 1'b0;
    end else if (redirect) begin
      pc         <= redirect_pc;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight   <= 1'b0;
      kill       <= inflight;
      halt       <= |redirect_pc[1:0];
      misal_pend <= |redirect_pc[1:0];
    end else begin
      inflight   <= accept;
      kill       <= 1'b0;
      misal_pend <= 1'b0;
      if (accept) begin
        pc           <= pc + 32'd4;
        inflight_pc  <= pc;
        inflight_err <= fe_error;
      end
      if (rsp_push && inflight_err) begin
        halt <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; no reset needed since count qualifies every read
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      q_pc[wr_ptr]    <= push_pc;
      q_insn[wr_ptr]  <= push_insn;
      q_cause[wr_ptr] <= push_cause;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder plus in-order scoreboard.
module tb_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic        fe_req;
  logic [29:0] fe_addr;
  logic        fe_ack;
  logic        fe_error;
  logic [31:0] fe_data;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_insn;
  logic [1:0]  de_cause;
  logic        de_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        err_en;
  logic        ack_seen;
  logic [29:0] addr_seen;
  logic [31:0] exp_pc;
  logic [29:0] held_addr;
  int          n_pop;
  int          errors;
  int          checks;

  fetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack),
    .fe_error(fe_error), .fe_data(fe_data),
    .de_valid(de_valid), .de_pc(de_pc), .de_insn(de_insn),
    .de_cause(de_cause), .de_ready(de_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  // Memory model: fault at 0x0001_0000 when enabled, data one cycle after ack
  assign fe_error = err_en && (fe_addr == 30'h0000_4000);

  always @(negedge clk) begin
    ack_seen  = fe_req & fe_ack;
    addr_seen = fe_addr;
  end

  always @(posedge clk) begin
    fe_data <= ack_seen ? img({addr_seen, 2'b00}) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-order scoreboard on the decode port
  task automatic observe();
    logic [1:0]  ec;
    logic [31:0] ei;
    if (de_valid) begin
      ec = (err_en && exp_pc == 32'h0001_0000) ? 2'b01 : 2'b00;
      ei = (ec != 2'b00) ? 32'h0 : img(exp_pc);
      check("de_pc", de_pc, exp_pc);
      check("de_insn", de_insn, ei);
      check("de_cause", 32'(de_cause), 32'(ec));
      if (de_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; n_pop = 0;
    reset_n = 1'b0; fe_ack = 1'b1; de_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; err_en = 1'b0;
    exp_pc = 32'h100; held_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_fe_req", 32'(fe_req), 32'd0);
    check("rst_de_valid", 32'(de_valid), 32'd0);
    check("rst_de_pc", de_pc, 32'h0);
    check("rst_de_insn", de_insn, 32'h0);
    check("rst_de_cause", 32'(de_cause), 32'd0);

    // Streaming from RESET_PC
    tick(); reset_n = 1'b1; #1;
    check("c0_fe_req", 32'(fe_req), 32'd1);
    check("c0_fe_addr", 32'(fe_addr), 32'h40);
    check("c0_de_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("c1_de_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("c2_de_valid", 32'(de_valid), 32'd1);
    observe();
    repeat (6) begin
      tick(); #1;
      check("stream_valid", 32'(de_valid), 32'd1);
      observe();
    end

    // Backpressure
    repeat (10) begin
      tick(); de_ready = 1'b0; #1;
      observe();
    end
    check("bp_fe_req", 32'(fe_req), 32'd0);
    check("bp_de_valid", 32'(de_valid), 32'd1);
    repeat (10) begin
      tick(); de_ready = 1'b1; #1;
      observe();
    end

    // Ack stall: address held, order preserved
    tick(); fe_ack = 1'b0; #1;
    held_addr = fe_addr;
    check("stall_req", 32'(fe_req), 32'd1);
    observe();
    repeat (2) begin
      tick(); #1;
      check("stall_req", 32'(fe_req), 32'd1);
      check("stall_addr", 32'(fe_addr), 32'(held_addr));
      observe();
    end
    repeat (8) begin
      tick(); fe_ack = 1'b1; #1;
      observe();
    end

    // Reset mid-operation
    tick(); reset_n = 1'b0; #1;
    check("mrst_fe_req", 32'(fe_req), 32'd0);
    tick(); reset_n = 1'b1; #1;
    exp_pc = 32'h100;
    check("mrst_de_valid", 32'(de_valid), 32'd0);
    check("mrst_fe_addr", 32'(fe_addr), 32'h40);
    tick(); #1;
    tick(); #1;
    check("mrst_c2_valid", 32'(de_valid), 32'd1);
    observe();

    // Access fault at 0x0001_0000
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_FFF8; err_en = 1'b1; #1;
    check("rd_fe_req", 32'(fe_req), 32'd0);
    exp_pc = 32'h0000_FFF8; n_pop = 0;
    tick(); redirect = 1'b0; #1;
    check("flt_de_valid", 32'(de_valid), 32'd0);
    check("flt_fe_addr", 32'(fe_addr), 32'h3FFE);
    repeat (6) begin
      tick(); #1;
      observe();
    end
    check("flt_halt_req", 32'(fe_req), 32'd0);
    check("flt_no_more", 32'(de_valid), 32'd0);
    check("flt_entries", 32'(n_pop), 32'd3);

    // Redirect out of halt to 0x200
    tick(); redirect = 1'b1; redirect_pc = 32'h200; err_en = 1'b0; #1;
    exp_pc = 32'h200;
    tick(); redirect = 1'b0; #1;
    check("r200_fe_req", 32'(fe_req), 32'd1);
    check("r200_fe_addr", 32'(fe_addr), 32'h80);
    check("r200_n1_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("r200_n2_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("r200_n3_valid", 32'(de_valid), 32'd1);
    observe();
    repeat (2) begin
      tick(); #1;
      observe();
    end

    // Redirect with a response inflight (ack at 0x10C)
    tick(); redirect = 1'b1; redirect_pc = 32'h104; #1;
    exp_pc = 32'h104;
    tick(); redirect = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    check("kill_ack_addr", 32'(fe_addr), 32'h43);
    observe();
    tick(); redirect = 1'b1; redirect_pc = 32'h400; #1;
    check("kill_rd_req", 32'(fe_req), 32'd0);
    exp_pc = 32'h400;
    tick(); redirect = 1'b0; #1;
    check("kill_n1_valid", 32'(de_valid), 32'd0);
    check("kill_n1_addr", 32'(fe_addr), 32'h100);
    tick(); #1;
    check("kill_n2_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("kill_n3_valid", 32'(de_valid), 32'd1);
    observe();

    // Misaligned redirect
    tick(); redirect = 1'b1; redirect_pc = 32'h402; #1;
    tick(); redirect = 1'b0; #1;
    check("mis_n1_req", 32'(fe_req), 32'd0);
    check("mis_n1_valid", 32'(de_valid), 32'd0);
    tick(); #1;
    check("mis_valid", 32'(de_valid), 32'd1);
    check("mis_pc", de_pc, 32'h402);
    check("mis_insn", de_insn, 32'h0);
    check("mis_cause", 32'(de_cause), 32'd2);
    check("mis_req", 32'(fe_req), 32'd0);
    repeat (3) begin
      tick(); #1;
      check("mis_after_valid", 32'(de_valid), 32'd0);
      check("mis_after_req", 32'(fe_req), 32'd0);
    end
    tick(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    tick(); redirect = 1'b0; #1;
    check("mis_clear_req", 32'(fe_req), 32'd1);
    check("mis_clear_addr", 32'(fe_addr), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
